cpu8_control_unit: RTL and testbench

Multi-cycle control and writeback block for the 8-bit CPU. It fetches 16-bit instructions from a synchronous instruction ROM, decodes them, and drives the register file's read/write addresses, write strobe and write data. It also contains the datapath ALU and the writeback mux. The block sits directly upstream of the register file, consumes its two read ports, and sequences data-memory loads and stores.

---
 rtl/cpu8_pkg.sv | 74 +++++++
 rtl/alu8.sv | 25 ++
 rtl/cpu8_control_unit.sv | 166 ++++++++++++++++
 tb/tb_cpu8_control_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu8_pkg.sv
// Shared encodings for the 8-bit CPU control unit: opcodes, FSM states, writeback/ALU selects,
// and instruction field positions.
package cpu8_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_MOV  = 4'hD;
  localparam logic [3:0] OP_RSV  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_IMM = 2'd1,
    WB_RS1 = 2'd2,
    WB_MEM = 2'd3
  } wb_sel_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_t;

  function automatic alu_op_t alu_op_of(input logic [3:0] opc);
    alu_op_t r;
    case (opc)
      OP_ADD:  r = ALU_ADD;
      OP_SUB:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      OP_OR:   r = ALU_OR;
      OP_XOR:  r = ALU_XOR;
      OP_SHL:  r = ALU_SHL;
      OP_SHR:  r = ALU_SHR;
      default: r = ALU_PASS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU; results wrap, carry/borrow dropped, shifts zero-fill.
module alu8
  import cpu8_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  always_comb begin
    y = a;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SHL: y = {a[6:0], 1'b0};
      ALU_SHR: y = {1'b0, a[7:1]};
      default: y = a;
    endcase
  end

endmodule

// File: rtl/cpu8_control_unit.sv
// Multi-cycle fetch/decode/execute control + writeback for the 8-bit CPU; 3 cycles/instr, LD 4.
// No backpressure. Define ILLEGAL_OP_TRAP_EN to trap opcode E (illegal=1, halt); else it is a NOP.
module cpu8_control_unit
  import cpu8_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
)
(
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [2:0]  rf_readadd1,
  output logic [2:0]  rf_readadd2,
  input  logic [7:0]  rf_readdata1,
  input  logic [7:0]  rf_readdata2,
  output logic [2:0]  rf_writeadd,
  output logic [7:0]  rf_writedata,
  output logic        rf_regwrite,
  output logic [7:0]  dmem_addr,
  output logic [7:0]  dmem_wdata,
  output logic        dmem_we,
  input  logic [7:0]  dmem_rdata,
  output logic        halted,
  output logic        illegal
);

  state_t     state, state_nxt;
  logic [7:0] pc, pc_nxt;
  logic [15:0] ir;

  logic [3:0] op;
  logic [2:0] rd, rs1, rs2;
  logic [7:0] imm8;

  alu_op_t    alu_op;
  wb_sel_t    wb_sel;
  logic [7:0] alu_y;
  logic       wr_en;
  logic       st_en;
  logic       illegal_set;

  assign op   = ir[OP_MSB:OP_LSB];
  assign rd   = ir[RD_MSB:RD_LSB];
  assign rs1  = ir[RS1_MSB:RS1_LSB];
  assign rs2  = ir[RS2_MSB:RS2_LSB];
  assign imm8 = ir[IMM_MSB:IMM_LSB];

  // BZ tests rd, so it borrows read port 1.
  assign rf_readadd1 = (op == OP_BZ) ? rd : rs1;
  assign rf_readadd2 = rs2;
  assign rf_writeadd = rd;
  assign imem_addr   = pc;
  assign dmem_addr   = rf_readdata1;
  assign dmem_wdata  = rf_readdata2;

  alu8 u_alu (
    .op (alu_op),
    .a  (rf_readdata1),
    .b  (rf_readdata2),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == S_DECODE) begin
        ir <= imem_rdata;
      end
    end
  end

  // A taken jump/branch in EXECUTE overrides the increment made in DECODE.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    illegal_set = 1'b0;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        state_nxt = S_EXECUTE;
        pc_nxt    = pc + 8'd1;
      end
      S_EXECUTE: begin
        state_nxt = S_FETCH;
        case (op)
          OP_LD:   state_nxt = S_MEM;
          OP_JMP:  pc_nxt = imm8;
          OP_BZ: begin
            if (rf_readdata1 == 8'h00) begin
              pc_nxt = imm8;
            end
          end
          OP_HALT: state_nxt = S_HALTED;
`ifdef ILLEGAL_OP_TRAP_EN
          OP_RSV: begin
            state_nxt   = S_HALTED;
            illegal_set = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_MEM:    state_nxt = S_FETCH;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    alu_op = alu_op_of(op);
    wb_sel = WB_ALU;
    wr_en  = 1'b0;
    st_en  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: wr_en = 1'b1;
      OP_LDI: begin
        wb_sel = WB_IMM;
        wr_en  = 1'b1;
      end
      OP_MOV: begin
        wb_sel = WB_RS1;
        wr_en  = 1'b1;
      end
      OP_ST:   st_en = 1'b1;
      default: ;
    endcase
    if (state == S_MEM) begin
      wb_sel = WB_MEM;
    end

    case (wb_sel)
      WB_ALU:  rf_writedata = alu_y;
      WB_IMM:  rf_writedata = imm8;
      WB_RS1:  rf_writedata = rf_readdata1;
      default: rf_writedata = dmem_rdata;
    endcase

    // Strobes are masked by rst so an abandoned instruction never commits.
    rf_regwrite = ~rst & (((state == S_EXECUTE) & wr_en) | (state == S_MEM));
    dmem_we     = ~rst & (state == S_EXECUTE) & st_en;
    halted      = (state == S_HALTED);
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (illegal_set) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu8_control_unit.sv
// Directed bench for cpu8_control_unit: per-cycle vector table over one program, then an
// ALU/opcode-E/HALT sequence with a second program.
module tb_cpu8_control_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [2:0]  rf_readadd1, rf_readadd2, rf_writeadd;
  logic [7:0]  rf_readdata1, rf_readdata2, rf_writedata;
  logic        rf_regwrite;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we;
  logic        halted, illegal;

  logic [15:0] rom  [256];
  logic [7:0]  dmem [256];
  logic [7:0]  regs [8];

  int n_vec;
  int n_bad;

  cpu8_control_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .rf_readadd1  (rf_readadd1),
    .rf_readadd2  (rf_readadd2),
    .rf_readdata1 (rf_readdata1),
    .rf_readdata2 (rf_readdata2),
    .rf_writeadd  (rf_writeadd),
    .rf_writedata (rf_writedata),
    .rf_regwrite  (rf_regwrite),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_we      (dmem_we),
    .dmem_rdata   (dmem_rdata),
    .halted       (halted),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, data memory and a combinational-read register file around the DUT.
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  always @(posedge clk) begin
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= dmem[dmem_addr];
  end

  always @(posedge clk) if (rf_regwrite) regs[rf_writeadd] <= rf_writedata;

  assign rf_readdata1 = regs[rf_readadd1];
  assign rf_readdata2 = regs[rf_readadd2];

  typedef struct {
    logic       rst;
    logic [7:0] addr;
    logic       rw;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       we;
    logic [7:0] da;
    logic [7:0] dd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [7:0] a, input logic rw,
                              input logic [2:0] wa, input logic [7:0] wd,
                              input logic we, input logic [7:0] da, input logic [7:0] dd);
    vec_t v;
    v.rst = r; v.addr = a; v.rw = rw; v.wa = wa; v.wd = wd;
    v.we = we; v.da = da; v.dd = dd;
    return v;
  endfunction

  function automatic vec_t idl(input logic [7:0] a);
    return mk(1'b0, a, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00);
  endfunction

  function automatic vec_t wr(input logic [7:0] a, input logic [2:0] wa, input logic [7:0] wd);
    return mk(1'b0, a, 1'b1, wa, wd, 1'b0, 8'h00, 8'h00);
  endfunction

  function automatic vec_t rstv(input logic [7:0] a);
    return mk(1'b1, a, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00);
  endfunction

  task automatic check(input string name, input logic [7:0] addr, input logic rw,
                       input logic [2:0] wa, input logic [7:0] wd, input logic we,
                       input logic [7:0] da, input logic [7:0] dd,
                       input logic hl, input logic il);
    logic ok;
    ok = (imem_addr === addr) && (rf_regwrite === rw) && (dmem_we === we) &&
         (halted === hl) && (illegal === il);
    if (rw) ok = ok && (rf_writeadd === wa) && (rf_writedata === wd);
    if (we) ok = ok && (dmem_addr === da) && (dmem_wdata === dd);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got addr=%h rw=%b wa=%0d wd=%h we=%b da=%h dd=%h halted=%b illegal=%b; want addr=%h rw=%b wa=%0d wd=%h we=%b da=%h dd=%h halted=%b illegal=%b",
               name, imem_addr, rf_regwrite, rf_writeadd, rf_writedata, dmem_we, dmem_addr,
               dmem_wdata, halted, illegal, addr, rw, wa, wd, we, da, dd, hl, il);
    end
  endtask

  logic [7:0] p2_exp [5];

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h8205; // LDI r1,05
    rom[8'h01] = 16'h84FB; // LDI r2,FB
    rom[8'h02] = 16'h1650; // ADD r3,r1,r2
    rom[8'h03] = 16'h8810; // LDI r4,10
    rom[8'h04] = 16'hA108; // ST [r4]=r1
    rom[8'h05] = 16'h9B00; // LD r5,[r4]
    rom[8'h06] = 16'hC620; // BZ r3,20
    rom[8'h20] = 16'hC220; // BZ r1,20
    rom[8'h21] = 16'hB0FE; // JMP FE
    rom[8'hFE] = 16'hDD40; // MOV r6,r5
    rom[8'hFF] = 16'h2E50; // SUB r7,r1,r2

    // One row per clock period after the two reset cycles.
    vecs.push_back(rstv(8'h00));
    vecs.push_back(rstv(8'h00));
    vecs.push_back(idl(8'h00)); vecs.push_back(idl(8'h00)); vecs.push_back(wr(8'h01, 3'd1, 8'h05));
    vecs.push_back(idl(8'h01)); vecs.push_back(idl(8'h01)); vecs.push_back(wr(8'h02, 3'd2, 8'hFB));
    vecs.push_back(idl(8'h02)); vecs.push_back(idl(8'h02)); vecs.push_back(wr(8'h03, 3'd3, 8'h00));
    vecs.push_back(idl(8'h03)); vecs.push_back(idl(8'h03)); vecs.push_back(wr(8'h04, 3'd4, 8'h10));
    vecs.push_back(idl(8'h04)); vecs.push_back(idl(8'h04));
    vecs.push_back(mk(1'b0, 8'h05, 1'b0, 3'd0, 8'h00, 1'b1, 8'h10, 8'h05));
    vecs.push_back(idl(8'h05)); vecs.push_back(idl(8'h05)); vecs.push_back(idl(8'h06));
    vecs.push_back(wr(8'h06, 3'd5, 8'h05));
    vecs.push_back(idl(8'h06)); vecs.push_back(idl(8'h06)); vecs.push_back(idl(8'h07));
    vecs.push_back(idl(8'h20)); vecs.push_back(idl(8'h20)); vecs.push_back(idl(8'h21));
    vecs.push_back(idl(8'h21)); vecs.push_back(idl(8'h21)); vecs.push_back(idl(8'h22));
    vecs.push_back(idl(8'hFE)); vecs.push_back(idl(8'hFE)); vecs.push_back(wr(8'hFF, 3'd6, 8'h05));
    vecs.push_back(idl(8'hFF)); vecs.push_back(idl(8'hFF)); vecs.push_back(wr(8'h00, 3'd7, 8'h0A));
    vecs.push_back(idl(8'h00)); vecs.push_back(idl(8'h00)); vecs.push_back(wr(8'h01, 3'd1, 8'h05));
    vecs.push_back(idl(8'h01)); vecs.push_back(idl(8'h01)); vecs.push_back(wr(8'h02, 3'd2, 8'hFB));
    vecs.push_back(idl(8'h02)); vecs.push_back(idl(8'h02)); vecs.push_back(wr(8'h03, 3'd3, 8'h00));
    vecs.push_back(idl(8'h03)); vecs.push_back(idl(8'h03)); vecs.push_back(wr(8'h04, 3'd4, 8'h10));
    vecs.push_back(idl(8'h04)); vecs.push_back(idl(8'h04));
    vecs.push_back(rstv(8'h05)); // rst lands on ST's EXECUTE: store must not fire
    vecs.push_back(idl(8'h00)); vecs.push_back(idl(8'h00)); vecs.push_back(wr(8'h01, 3'd1, 8'h05));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      #1;
      check($sformatf("row%0d", i), vecs[i].addr, vecs[i].rw, vecs[i].wa, vecs[i].wd,
            vecs[i].we, vecs[i].da, vecs[i].dd, 1'b0, 1'b0);
    end

    // Second program: remaining ALU ops, opcode E, then HALT.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h8296; // LDI r1,96
    rom[8'h01] = 16'h843C; // LDI r2,3C
    rom[8'h02] = 16'h3650; // AND r3
    rom[8'h03] = 16'h4650; // OR  r3
    rom[8'h04] = 16'h5650; // XOR r3
    rom[8'h05] = 16'h6640; // SHL r3,r1
    rom[8'h06] = 16'h7640; // SHR r3,r1
    rom[8'h07] = 16'hE000; // reserved
    rom[8'h08] = 16'h0000; // NOP
    rom[8'h09] = 16'hF000; // HALT
    p2_exp[0] = 8'h14;
    p2_exp[1] = 8'hBE;
    p2_exp[2] = 8'hAA;
    p2_exp[3] = 8'h2C;
    p2_exp[4] = 8'h4B;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      if (c == 1) begin
        check("p2_reset", 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      end else if (c >= 9 && c <= 21 && (c % 3) == 0) begin
        check($sformatf("p2_alu%0d", c / 3 - 3), 8'(c / 3), 1'b1, 3'd3, p2_exp[c / 3 - 3],
              1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
      end else if (c >= 25 && c <= 34) begin
        check("p2_trap", 8'h08, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
`else
      end else if (c == 25) begin
        check("p2_e_nop", 8'h08, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      end else if (c >= 31 && c <= 40) begin
        check("p2_halt", 8'h0A, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
`endif
      end
    end

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("halt_exit", 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
